led_fader: RTL and testbench

//  - Downstream stage of the LED sequence generator: consumes its NUM_CH-bit on/off pattern, drives the board LEDs.
//  - Each LED ramps brightness linearly toward full-on or off instead of switching hard.
//  - Brightness is rendered as per-channel PWM; output pins connect straight to the Arty LEDs.

---
 rtl/led_fader_pkg.sv | 7 +
 rtl/led_fade_channel.sv | 55 +++++
 rtl/led_fader.sv | 60 ++++++
 tb/tb_led_fader.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/led_fader_pkg.sv
// led_fader_pkg: channel state type and LVL_MAX helper shared by led_fader and led_fade_channel
package led_fader_pkg;
  typedef enum logic [1:0] {CH_OFF, CH_RISE, CH_ON, CH_FALL} ch_state_t;
  function automatic int lvl_max(input int width);
    return (1 << width) - 1;
  endfunction
endpackage

// File: rtl/led_fade_channel.sv
// led_fade_channel: one LED level ramp plus PWM compare; LED_FADER_GAMMA_EN selects a registered gamma-2 duty
module led_fade_channel
  import led_fader_pkg::*;
#(
  parameter int PWM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 target_on,
  input  logic                 step_tick,
  input  logic [PWM_WIDTH-1:0] pwm_cnt,
  output logic                 led,
  output logic                 settled
);
  localparam logic [PWM_WIDTH-1:0] LVL_MAX = PWM_WIDTH'(lvl_max(PWM_WIDTH));
  ch_state_t state;
  logic [PWM_WIDTH-1:0] level_q, level_d, target, duty;
  logic led_q, led_d;
`ifdef LED_FADER_GAMMA_EN
  logic [PWM_WIDTH-1:0] duty_q, duty_d;
`endif
  always_comb begin
    target = target_on ? LVL_MAX : '0;
    state = level_q < target ? CH_RISE : level_q > target ? CH_FALL : target_on ? CH_ON : CH_OFF;
    level_d = !step_tick ? level_q :
              state == CH_RISE ? level_q + PWM_WIDTH'(1) :
              state == CH_FALL ? level_q - PWM_WIDTH'(1) : level_q;
`ifdef LED_FADER_GAMMA_EN
    duty_d = level_q == LVL_MAX ? LVL_MAX :
             PWM_WIDTH'(({{PWM_WIDTH{1'b0}}, level_q} * {{PWM_WIDTH{1'b0}}, level_q}) >> PWM_WIDTH);
    duty = duty_q;
`else
    duty = level_q;
`endif
    led_d = enable && pwm_cnt < duty;
    settled = level_q == target;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q <= '0;
      led_q <= 1'b0;
`ifdef LED_FADER_GAMMA_EN
      duty_q <= '0;
`endif
    end else begin
      level_q <= level_d;
      led_q <= led_d;
`ifdef LED_FADER_GAMMA_EN
      duty_q <= duty_d;
`endif
    end
  end
  assign led = led_q;
endmodule

// File: rtl/led_fader.sv
// led_fader: fades NUM_CH LEDs toward pattern_in with per-channel PWM; define LED_FADER_GAMMA_EN for gamma-2 duty
module led_fader
  import led_fader_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int PWM_WIDTH = 8,
  parameter int STEP_DIV  = 98_000,
  parameter int DIV_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [NUM_CH-1:0] pattern_in,
  output logic [NUM_CH-1:0] led_out,
  output logic              busy,
  output logic              pwm_sync
);
  localparam logic [PWM_WIDTH-1:0] LVL_MAX = PWM_WIDTH'(lvl_max(PWM_WIDTH));
  logic [NUM_CH-1:0] pattern_q, pattern_d, settled;
  logic [DIV_WIDTH-1:0] step_cnt_q, step_cnt_d;
  logic [PWM_WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
  logic busy_q, busy_d, pwm_sync_q, pwm_sync_d, step_tick;
  always_comb begin
    step_tick = enable && step_cnt_q == DIV_WIDTH'(STEP_DIV - 1);
    pattern_d = pattern_in;
    step_cnt_d = !enable ? step_cnt_q : step_tick ? '0 : step_cnt_q + DIV_WIDTH'(1);
    pwm_cnt_d = !enable ? pwm_cnt_q : pwm_cnt_q == LVL_MAX - PWM_WIDTH'(1) ? '0 : pwm_cnt_q + PWM_WIDTH'(1);
    busy_d = ~&settled;
    pwm_sync_d = enable && pwm_cnt_q == '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pattern_q <= '0;
      step_cnt_q <= '0;
      pwm_cnt_q <= '0;
      busy_q <= 1'b0;
      pwm_sync_q <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      step_cnt_q <= step_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
      busy_q <= busy_d;
      pwm_sync_q <= pwm_sync_d;
    end
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    led_fade_channel #(.PWM_WIDTH(PWM_WIDTH)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (enable),
      .target_on(pattern_q[i]),
      .step_tick(step_tick),
      .pwm_cnt  (pwm_cnt_q),
      .led      (led_out[i]),
      .settled  (settled[i])
    );
  end
  assign busy = busy_q;
  assign pwm_sync = pwm_sync_q;
endmodule

// File: tb/tb_led_fader.sv
// tb_led_fader: directed fade scenarios checked every cycle against an arithmetic model of the fader
module tb_led_fader;
  localparam int NC = 4, PW = 4, SD = 2, LM = 15;
  logic clk = 0, rst_n = 0, enable = 0;
  logic [NC-1:0] pattern_in = '0, led_out;
  logic busy, pwm_sync;
  int errors = 0, checks = 0;
  int m_pat = 0, m_step = 0, m_pwm = 0;
  int m_lvl[NC] = '{0, 0, 0, 0};
  int m_duty[NC] = '{0, 0, 0, 0};
  logic [NC-1:0] m_led = '0;
  logic m_busy = 0, m_sync = 0;
  bit chk_on = 0;
  always #5 clk = ~clk;
  led_fader #(.NUM_CH(NC), .PWM_WIDTH(PW), .STEP_DIV(SD), .DIV_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_in(pattern_in),
    .led_out(led_out), .busy(busy), .pwm_sync(pwm_sync)
  );
  function automatic int tgt(int p, int i);
    return ((p >> i) & 1) != 0 ? LM : 0;
  endfunction
  function automatic int toward(int t, int l);
    return t > l ? l + 1 : t < l ? l - 1 : l;
  endfunction
  function automatic logic any_busy();
    for (int i = 0; i < NC; i++) if (m_lvl[i] != tgt(m_pat, i)) return 1'b1;
    return 1'b0;
  endfunction
  function automatic int shown_duty(int i);
`ifdef LED_FADER_GAMMA_EN
    return m_duty[i];
`else
    return m_lvl[i];
`endif
  endfunction
  function automatic int lvl_of(int ch);
    case (ch)
      0: return int'(dut.g_ch[0].u_ch.level_q);
      1: return int'(dut.g_ch[1].u_ch.level_q);
      2: return int'(dut.g_ch[2].u_ch.level_q);
      default: return int'(dut.g_ch[3].u_ch.level_q);
    endcase
  endfunction
  always @(posedge clk) begin
    if (!rst_n) begin
      m_pat <= 0; m_step <= 0; m_pwm <= 0; m_led <= '0; m_busy <= 0; m_sync <= 0;
      for (int i = 0; i < NC; i++) begin m_lvl[i] <= 0; m_duty[i] <= 0; end
    end else begin
      m_pat <= int'(pattern_in);
      if (enable) begin m_step <= (m_step + 1) % SD; m_pwm <= (m_pwm + 1) % LM; end
      for (int i = 0; i < NC; i++) begin
        if (enable && m_step == SD - 1) m_lvl[i] <= toward(tgt(m_pat, i), m_lvl[i]);
        m_duty[i] <= m_lvl[i] == LM ? LM : (m_lvl[i] * m_lvl[i]) / 16;
        m_led[i] <= enable && m_pwm < shown_duty(i);
      end
      m_busy <= any_busy();
      m_sync <= enable && m_pwm == 0;
    end
  end
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (chk_on) begin
      chk("model led_out", 32'(led_out), 32'(m_led));
      chk("model busy", 32'(busy), 32'(m_busy));
      chk("model pwm_sync", 32'(pwm_sync), 32'(m_sync));
      for (int i = 0; i < NC; i++) chk("model level", lvl_of(i), m_lvl[i]);
    end
  end
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_lvl(int ch, int v, int lim, string n);
    int k = 0;
    while (lvl_of(ch) != v && k < lim) begin @(negedge clk); k++; end
    chk(n, lvl_of(ch) == v, 1);
  endtask
  initial begin
    int mx;
    rst_n = 0; enable = 1; pattern_in = 4'hF;
    cyc(1);
    chk_on = 1;
    for (int i = 0; i < 5; i++) begin
      chk("reset led_out", led_out, 0);
      chk("reset busy", busy, 0);
      chk("reset pwm_sync", pwm_sync, 0);
      if (i < 4) cyc(1);
    end
    rst_n = 1; pattern_in = 4'b0001;
    cyc(1);
    chk("busy one cycle", busy, 0);
    cyc(1);
    chk("busy two cycles", busy, 1);
    cyc(28);
    chk("rise level0 15", lvl_of(0), 15);
    chk("busy before settle", busy, 1);
    cyc(1);
    chk("busy settled", busy, 0);
    cyc(1);
    for (int i = 0; i < 15; i++) begin cyc(1); chk("full on pattern", led_out, 4'b0001); end
    pattern_in = 4'b0000;
    wait_lvl(0, 8, 30, "fall reaches 8");
    wait_lvl(0, 0, 30, "fall reaches 0");
    pattern_in = 4'b0010;
    wait_lvl(1, 7, 40, "ch1 rises to 7");
    pattern_in = 4'b0000;
    cyc(2);
    chk("reverse to 6", lvl_of(1), 6);
    mx = lvl_of(1);
    for (int k = 0; k < 30 && lvl_of(1) > 0; k++) begin cyc(1); if (lvl_of(1) > mx) mx = lvl_of(1); end
    chk("reverse never above 7", mx <= 7, 1);
    chk("reverse ends at 0", lvl_of(1), 0);
    pattern_in = 4'b0100;
    wait_lvl(2, 5, 40, "ch2 rises to 5");
    enable = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("disabled led_out", led_out, 0);
      chk("disabled pwm_sync", pwm_sync, 0);
      chk("disabled level", lvl_of(2), 5);
    end
    enable = 1;
    cyc(1);
    chk("resume holds 5", lvl_of(2), 5);
    cyc(1);
    chk("resume steps to 6", lvl_of(2), 6);
    pattern_in = 4'b1000;
    wait_lvl(3, 10, 40, "ch3 rises to 10");
    rst_n = 0;
    cyc(1);
    for (int i = 0; i < NC; i++) chk("midfade reset level", lvl_of(i), 0);
    chk("midfade reset led_out", led_out, 0);
    chk("midfade reset busy", busy, 0);
    chk("midfade reset pwm_sync", pwm_sync, 0);
    rst_n = 1;
`ifdef LED_FADER_GAMMA_EN
    pattern_in = 4'b0001;
    wait_lvl(0, 8, 40, "gamma ch0 rises to 8");
    cyc(1);
    chk("gamma duty at level 8", int'(dut.g_ch[0].u_ch.duty_q), 4);
`endif
    cyc(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
